// File: rtl/vga_sync_gen_if.sv
// VGA output bundle: sync pulses plus one pixel of colour per clock.
interface vga_if #(
    parameter int COLOR_W = 4
);
    logic               hs;
    logic               vs;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;

    modport source (output hs, vs, red, green, blue);
    modport sink   (input  hs, vs, red, green, blue);
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: counts pixels/lines, requests colour by coordinate and
// drives sync and RGB through a two-stage pipeline so they stay aligned.
module vga_sync_gen #(
    parameter int H_ACT   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int COLOR_W = 4,
    parameter int X_W     = $clog2(H_ACT + H_FP + H_SYNC + H_BP),
    parameter int Y_W     = $clog2(V_ACT + V_FP + V_SYNC + V_BP)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    output logic [X_W-1:0]     x_o,
    output logic [Y_W-1:0]     y_o,
    output logic               req_o,
    output logic               frame_start_o,
    input  logic [COLOR_W-1:0] red_i,
    input  logic [COLOR_W-1:0] green_i,
    input  logic [COLOR_W-1:0] blue_i,
    vga_if.source              vga_out_if
);

    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

    localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOT - 1);
    localparam logic [X_W-1:0] H_ACT_C  = X_W'(H_ACT);
    localparam logic [X_W-1:0] H_SYNC_S = X_W'(H_ACT + H_FP);
    localparam logic [X_W-1:0] H_SYNC_E = X_W'(H_ACT + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOT - 1);
    localparam logic [Y_W-1:0] V_ACT_C  = Y_W'(V_ACT);
    localparam logic [Y_W-1:0] V_SYNC_S = Y_W'(V_ACT + V_FP);
    localparam logic [Y_W-1:0] V_SYNC_E = Y_W'(V_ACT + V_FP + V_SYNC);

    logic [X_W-1:0]     h_cnt;
    logic [Y_W-1:0]     v_cnt;
    logic               h_last;
    logic               v_last;

    logic               req;
    logic               hs_act;
    logic               vs_act;

    logic               req_d1;
    logic               hs_act_d1;
    logic               vs_act_d1;

    logic               hs_q;
    logic               vs_q;
    logic [COLOR_W-1:0] red_q;
    logic [COLOR_W-1:0] green_q;
    logic [COLOR_W-1:0] blue_q;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // Line wrap carries into the line counter; both wrap together at frame end.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en_i) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign req    = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign hs_act = (h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E);
    assign vs_act = (v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E);

    assign x_o           = h_cnt;
    assign y_o           = v_cnt;
    assign req_o         = req;
    assign frame_start_o = en_i && (h_cnt == '0) && (v_cnt == '0);

    // Stage 1: the colour source answers the stage-0 request during this cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_d1    <= 1'b0;
            hs_act_d1 <= 1'b0;
            vs_act_d1 <= 1'b0;
        end else if (en_i) begin
            req_d1    <= req;
            hs_act_d1 <= hs_act;
            vs_act_d1 <= vs_act;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else if (en_i) begin
            hs_q    <= hs_act_d1 ? HS_POL : ~HS_POL;
            vs_q    <= vs_act_d1 ? VS_POL : ~VS_POL;
            red_q   <= req_d1 ? red_i   : '0;
            green_q <= req_d1 ? green_i : '0;
            blue_q  <= req_d1 ? blue_i  : '0;
        end
    end

    assign vga_out_if.hs    = hs_q;
    assign vga_out_if.vs    = vs_q;
    assign vga_out_if.red   = red_q;
    assign vga_out_if.green = green_q;
    assign vga_out_if.blue  = blue_q;

endmodule
